// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM request front end.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 32;
  localparam int SDRAM_BE_W   = SDRAM_DATA_W / 8;

  // One queued host request; also the bundle presented on ctl_*.
  typedef struct packed {
    logic                    we;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [SDRAM_DATA_W-1:0] wdata;
    logic [SDRAM_BE_W-1:0]   be;
  } sdram_req_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// In-order request queue with registered storage. When empty, the head
// output keeps showing the most recently popped entry.
import sdram_pkg::*;

module sdram_req_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  sdram_req_t                   i_data,
  output sdram_req_t                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  sdram_req_t             r_mem [DEPTH];
  sdram_req_t             r_last;
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [CNT_W-1:0]       r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_head  = o_empty ? r_last : r_mem[r_rptr];

endmodule

// File: rtl/sdram_req_frontend.sv
// Host request queue, read-credit limiter and registered read return for the
// SDRAM controller. Define SDRAM_FE_PERF_EN to add rd_issued/wr_issued counters.
import sdram_pkg::*;

module sdram_req_frontend #(
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int DATA_W = SDRAM_DATA_W,
  parameter int DEPTH  = 4,
  parameter int MAX_RD = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         host_valid,
  output logic                         host_ready,
  input  logic                         host_we,
  input  logic [ADDR_W-1:0]            host_addr,
  input  logic [DATA_W-1:0]            host_wdata,
  input  logic [DATA_W/8-1:0]          host_be,
  output logic                         host_rvalid,
  output logic [DATA_W-1:0]            host_rdata,
  output logic                         ctl_valid,
  input  logic                         ctl_ready,
  output logic                         ctl_we,
  output logic [ADDR_W-1:0]            ctl_addr,
  output logic [DATA_W-1:0]            ctl_wdata,
  output logic [DATA_W/8-1:0]          ctl_be,
  input  logic                         ctl_rvalid,
  input  logic [DATA_W-1:0]            ctl_rdata,
  output logic [$clog2(MAX_RD+1)-1:0]  rd_pending,
  output logic                         err
`ifdef SDRAM_FE_PERF_EN
  ,
  output logic [15:0]                  rd_issued,
  output logic [15:0]                  wr_issued
`endif
);

  localparam int RD_W  = $clog2(MAX_RD + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  sdram_req_t        w_in;
  sdram_req_t        w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_acc;
  logic              w_ret;
  logic              w_stray;

  logic [RD_W-1:0]   r_rd_pending;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  // Ready depends only on state, never on host_valid/host_we.
  assign host_ready = !rst && !w_full && (r_rd_pending < RD_W'(MAX_RD));
  assign w_push     = host_valid && host_ready;
  assign w_pop      = ctl_valid && ctl_ready;
  assign w_rd_acc   = w_push && !host_we;
  assign w_ret      = ctl_rvalid && (r_rd_pending != '0);
  assign w_stray    = ctl_rvalid && (r_rd_pending == '0);

  always_comb begin
    w_in       = '0;
    w_in.we    = host_we;
    w_in.addr  = host_addr;
    w_in.wdata = host_wdata;
    w_in.be    = host_be;
  end

  sdram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  a_count_empty: assert property (@(posedge clk) disable iff (rst)
    (w_count == '0) == w_empty);

  assign ctl_valid = !w_empty;
  assign ctl_we    = w_head.we;
  assign ctl_addr  = w_head.addr;
  assign ctl_wdata = w_head.wdata;
  assign ctl_be    = w_head.be;

  // Credits are taken at host acceptance so queued reads count too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pending <= '0;
    end else begin
      case ({w_rd_acc, w_ret})
        2'b10:   r_rd_pending <= r_rd_pending + 1'b1;
        2'b01:   r_rd_pending <= r_rd_pending - 1'b1;
        default: r_rd_pending <= r_rd_pending;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_ret;
      if (w_ret)   r_rdata <= ctl_rdata;
      if (w_stray) r_err   <= 1'b1;
    end
  end

  assign rd_pending  = r_rd_pending;
  assign host_rvalid = r_rvalid;
  assign host_rdata  = r_rdata;
  assign err         = r_err;

`ifdef SDRAM_FE_PERF_EN
  logic [15:0] r_rd_issued;
  logic [15:0] r_wr_issued;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_issued <= '0;
      r_wr_issued <= '0;
    end else if (w_pop) begin
      if (w_head.we) begin
        if (r_wr_issued != 16'hFFFF) r_wr_issued <= r_wr_issued + 1'b1;
      end else begin
        if (r_rd_issued != 16'hFFFF) r_rd_issued <= r_rd_issued + 1'b1;
      end
    end
  end

  assign rd_issued = r_rd_issued;
  assign wr_issued = r_wr_issued;
`endif

endmodule

// File: tb/tb_sdram_req_frontend.sv
// Directed bench for sdram_req_frontend: queueing, credit limit, read return,
// stray-return error and mid-operation reset.
module tb_sdram_req_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_valid, host_ready, host_we;
  logic [23:0] host_addr;
  logic [31:0] host_wdata;
  logic [3:0]  host_be;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        ctl_valid, ctl_ready, ctl_we;
  logic [23:0] ctl_addr;
  logic [31:0] ctl_wdata;
  logic [3:0]  ctl_be;
  logic        ctl_rvalid;
  logic [31:0] ctl_rdata;
  logic [2:0]  rd_pending;
  logic        err;
`ifdef SDRAM_FE_PERF_EN
  logic [15:0] rd_issued, wr_issued;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_req_frontend dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_be(host_be),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_we(ctl_we),
    .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_be(ctl_be),
    .ctl_rvalid(ctl_rvalid), .ctl_rdata(ctl_rdata),
    .rd_pending(rd_pending), .err(err)
`ifdef SDRAM_FE_PERF_EN
    , .rd_issued(rd_issued), .wr_issued(wr_issued)
`endif
  );

  // Advance one edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; host_valid = 1'b0; host_we = 1'b0; host_addr = '0;
    host_wdata = '0; host_be = '0; ctl_ready = 1'b0; ctl_rvalid = 1'b0;
    ctl_rdata = '0;
    tick(); tick();
    checks++; if (host_ready !== 1'b0) begin failures++; $display("FAIL rst_host_ready got=%0b exp=0", host_ready); end
    checks++; if (ctl_valid !== 1'b0) begin failures++; $display("FAIL rst_ctl_valid got=%0b exp=0", ctl_valid); end
    checks++; if ({ctl_we, ctl_addr, ctl_wdata, ctl_be} !== 61'd0) begin failures++; $display("FAIL rst_ctl_fields got=%h exp=0", {ctl_we, ctl_addr, ctl_wdata, ctl_be}); end
    checks++; if ({host_rvalid, host_rdata} !== 33'd0) begin failures++; $display("FAIL rst_host_r got=%h exp=0", {host_rvalid, host_rdata}); end
    checks++; if ({rd_pending, err} !== 4'd0) begin failures++; $display("FAIL rst_pend_err got=%h exp=0", {rd_pending, err}); end
    rst = 1'b0;
    #1;
    checks++; if (host_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%0b exp=1", host_ready); end
  endtask

  task automatic test_single_write();
    ctl_ready = 1'b1;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 24'h000010;
    host_wdata = 32'hDEADBEEF; host_be = 4'hF;
    tick();
    host_valid = 1'b0;
    checks++; if (ctl_valid !== 1'b1) begin failures++; $display("FAIL wr_ctl_valid got=%0b exp=1", ctl_valid); end
    checks++; if ({ctl_we, ctl_addr, ctl_wdata, ctl_be} !== {1'b1, 24'h000010, 32'hDEADBEEF, 4'hF}) begin failures++; $display("FAIL wr_fields got=%h exp=%h", {ctl_we, ctl_addr, ctl_wdata, ctl_be}, {1'b1, 24'h000010, 32'hDEADBEEF, 4'hF}); end
    tick();
    checks++; if (ctl_valid !== 1'b0) begin failures++; $display("FAIL wr_popped got=%0b exp=0", ctl_valid); end
    checks++; if (ctl_addr !== 24'h000010 || ctl_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_hold_last got=%h/%h exp=000010/deadbeef", ctl_addr, ctl_wdata); end
    checks++; if (rd_pending !== 3'd0) begin failures++; $display("FAIL wr_rd_pending got=%0d exp=0", rd_pending); end
  endtask

  // Write pointer starts at 1 here, so the fill and drain wrap the queue.
  task automatic test_fill_drain();
    ctl_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_valid = 1'b1; host_we = 1'b1; host_addr = 24'h100 + 24'(i);
      host_wdata = 32'hA000_0000 + 32'(i); host_be = 4'(i + 1);
      tick();
    end
    host_valid = 1'b0;
    checks++; if (host_ready !== 1'b0) begin failures++; $display("FAIL full_host_ready got=%0b exp=0", host_ready); end
    tick();
    checks++; if (ctl_valid !== 1'b1 || ctl_addr !== 24'h100) begin failures++; $display("FAIL full_stall_head got=%0b/%h exp=1/000100", ctl_valid, ctl_addr); end
    ctl_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ctl_valid !== 1'b1 || ctl_addr !== 24'h100 + 24'(i) || ctl_wdata !== 32'hA000_0000 + 32'(i) || ctl_be !== 4'(i + 1)) begin failures++; $display("FAIL drain_%0d got=%0b/%h/%h/%h exp=1/%h/%h/%h", i, ctl_valid, ctl_addr, ctl_wdata, ctl_be, 24'h100 + 24'(i), 32'hA000_0000 + 32'(i), 4'(i + 1)); end
      tick();
      if (i == 0) begin
        checks++; if (host_ready !== 1'b1) begin failures++; $display("FAIL drain_ready got=%0b exp=1", host_ready); end
      end
    end
    checks++; if (ctl_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", ctl_valid); end
  endtask

  task automatic test_read_credit();
    ctl_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_valid = 1'b1; host_we = 1'b0; host_addr = 24'h200 + 24'(i);
      tick();
    end
    host_valid = 1'b0;
    checks++; if (rd_pending !== 3'd4) begin failures++; $display("FAIL credit_pending got=%0d exp=4", rd_pending); end
    checks++; if (host_ready !== 1'b0) begin failures++; $display("FAIL credit_ready got=%0b exp=0", host_ready); end
    ctl_rvalid = 1'b1; ctl_rdata = 32'h12345678;
    tick();
    ctl_rvalid = 1'b0; ctl_rdata = 32'hFFFF_FFFF;
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 32'h12345678) begin failures++; $display("FAIL ret_data got=%0b/%h exp=1/12345678", host_rvalid, host_rdata); end
    checks++; if (rd_pending !== 3'd3 || host_ready !== 1'b1) begin failures++; $display("FAIL ret_credit got=%0d/%0b exp=3/1", rd_pending, host_ready); end
    tick();
    checks++; if (host_rvalid !== 1'b0 || host_rdata !== 32'h12345678) begin failures++; $display("FAIL ret_hold got=%0b/%h exp=0/12345678", host_rvalid, host_rdata); end
  endtask

  task automatic test_simul_credit();
    ctl_rvalid = 1'b1; ctl_rdata = 32'h0000_0001;
    tick();
    checks++; if (rd_pending !== 3'd2) begin failures++; $display("FAIL simul_pre got=%0d exp=2", rd_pending); end
    host_valid = 1'b1; host_we = 1'b0; host_addr = 24'h300;
    ctl_rvalid = 1'b1; ctl_rdata = 32'hAAAA5555;
    tick();
    host_valid = 1'b0;
    checks++; if (rd_pending !== 3'd2) begin failures++; $display("FAIL simul_pending got=%0d exp=2", rd_pending); end
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 32'hAAAA5555) begin failures++; $display("FAIL simul_data got=%0b/%h exp=1/aaaa5555", host_rvalid, host_rdata); end
    ctl_rdata = 32'h0000_0002;
    tick();
    ctl_rdata = 32'h0000_0003;
    tick();
    ctl_rvalid = 1'b0;
    checks++; if (host_rdata !== 32'h0000_0003 || rd_pending !== 3'd0) begin failures++; $display("FAIL simul_drain got=%h/%0d exp=00000003/0", host_rdata, rd_pending); end
  endtask

  task automatic test_stray_return();
    tick();
    ctl_rvalid = 1'b1; ctl_rdata = 32'h0000_0BAD;
    tick();
    ctl_rvalid = 1'b0;
    checks++; if (host_rvalid !== 1'b0 || host_rdata !== 32'h0000_0003) begin failures++; $display("FAIL stray_dropped got=%0b/%h exp=0/00000003", host_rvalid, host_rdata); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL stray_err got=%0b exp=1", err); end
    tick(); tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%0b exp=0", err); end
  endtask

  task automatic test_mid_reset();
    ctl_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1; host_we = (i == 2); host_addr = 24'h400 + 24'(i);
      host_wdata = 32'h5A5A_0000 + 32'(i); host_be = 4'h3;
      tick();
    end
    host_valid = 1'b0;
    checks++; if (ctl_valid !== 1'b1 || rd_pending !== 3'd2) begin failures++; $display("FAIL mid_pre got=%0b/%0d exp=1/2", ctl_valid, rd_pending); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (ctl_valid !== 1'b0 || rd_pending !== 3'd0) begin failures++; $display("FAIL mid_flush got=%0b/%0d exp=0/0", ctl_valid, rd_pending); end
    checks++; if ({ctl_we, ctl_addr, ctl_wdata, ctl_be} !== 61'd0 || {host_rvalid, host_rdata, err} !== 34'd0) begin failures++; $display("FAIL mid_outputs got=%h/%h exp=0/0", {ctl_we, ctl_addr, ctl_wdata, ctl_be}, {host_rvalid, host_rdata, err}); end
    checks++; if (host_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b exp=1", host_ready); end
    ctl_rvalid = 1'b1; ctl_rdata = 32'h0000_0777;
    tick();
    ctl_rvalid = 1'b0;
    checks++; if (err !== 1'b1 || host_rvalid !== 1'b0) begin failures++; $display("FAIL mid_stale got=%0b/%0b exp=1/0", err, host_rvalid); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_drain();
    test_read_credit();
    test_simul_credit();
    test_stray_return();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_req_frontend.md
Name: sdram_req_frontend

Overview:
Host-side request stage that sits directly upstream of the SDRAM controller. It accepts 32-bit word read/write requests from the system bus and buffers them in a small in-order queue. It presents them one at a time to the controller with a valid/ready handshake, and returns controller read data to the host in order. It also bounds the number of outstanding reads so the read-return path can never overflow.

Parameters:
ADDR_W, 24, word address width (32-bit aligned words, 64MB space)
DATA_W, 32, data width; byte enables are DATA_W/8 bits
DEPTH, 4, request queue entries; must be a power of 2, at least 2
MAX_RD, 4, maximum reads accepted but not yet returned; at least 1

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
host_valid  in  1  host request present
host_ready  out  1  request accepted when host_valid && host_ready
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  word address
host_wdata  in  DATA_W  write data; ignored for reads
host_be  in  DATA_W/8  byte enables; ignored for reads
host_rvalid  out  1  read data valid, one-cycle pulse per read
host_rdata  out  DATA_W  read data
ctl_valid  out  1  request presented to the controller
ctl_ready  in  1  controller takes the request when ctl_valid && ctl_ready
ctl_we  out  1  head request type
ctl_addr  out  ADDR_W  head request address
ctl_wdata  out  DATA_W  head write data
ctl_be  out  DATA_W/8  head byte enables
ctl_rvalid  in  1  controller read data valid
ctl_rdata  in  DATA_W  controller read data
rd_pending  out  $clog2(MAX_RD+1)  outstanding read count
err  out  1  sticky protocol error

Behaviour:
- Reset values: host_ready=0 during the rst cycle; host_rvalid=0, host_rdata=0, ctl_valid=0, ctl_we/addr/wdata/be=0, rd_pending=0, err=0. Queue pointers and count are 0.
- Queue is an in-order FIFO with registered storage; the head entry drives the ctl_* fields directly.
- host_ready = !rst && (count<DEPTH) && (rd_pending<MAX_RD). This is deliberately independent of host_we and host_valid, so there is no combinational valid-to-ready path.
- Accept at edge N → entry visible on ctl_* with ctl_valid=1 from cycle N+1. There is no bypass; minimum host-to-controller latency is 1 cycle.
- ctl_valid = (count!=0). ctl_* are stable while ctl_valid && !ctl_ready. The head is popped on ctl_valid && ctl_ready.
- Simultaneous push and pop with count==DEPTH is impossible, because host_ready=0 when full. Simultaneous push and pop at any other count leaves count unchanged.
- When count==0, ctl_* fields hold the last popped value; ctl_valid=0.
- Pointers wrap modulo DEPTH.
- rd_pending increments when a read is accepted from the host (not when issued). It decrements on ctl_rvalid. If both happen in the same cycle, it is unchanged.
- ctl_rvalid with rd_pending==0: data is dropped, host_rvalid stays 0, err is set and held until rst.
- Read return: ctl_rvalid at cycle N → host_rvalid=1, host_rdata=ctl_rdata at cycle N+1 (registered, 1-cycle latency). host_rdata holds its value when host_rvalid=0. The host has no backpressure on read data; it must always sink host_rvalid.
- Writes generate no host response.
- Ordering: requests reach the controller in acceptance order; read data is returned in controller order, which is in-order.
- rst asserted mid-operation: the queue is flushed, rd_pending is cleared, and all queued requests are discarded. Any read data arriving afterwards for pre-reset reads sets err.

Optional Feature:
SDRAM_FE_PERF_EN: when defined, adds output ports rd_issued[15:0] and wr_issued[15:0]. These are saturating counters (stop at 16'hFFFF) incremented on each controller handshake of a read or a write, and cleared by rst. When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package sdram_pkg holds:
  - constants SDRAM_ADDR_W=24 and SDRAM_DATA_W=32;
  - typedef sdram_req_t, a packed struct of {we, addr, wdata, be}, used for the queue entry and the ctl_* bundle.
- One sub-module, sdram_req_fifo: parameterised DEPTH, sdram_req_t storage, push/pop/count/full/empty, synchronous rst. The read-credit and return logic stays in the top module.

Test Plan:
- Write addr 24'h000010, data 32'hDEADBEEF, be 4'hF, ctl_ready=1 → ctl_valid in the next cycle with identical fields; popped in one cycle; rd_pending stays 0.
- ctl_ready=0 and push 4 writes → host_ready=0 after the 4th accept. Raise ctl_ready → entries drain in order, 1 per cycle, and host_ready returns 1 after the first pop.
- 4 reads back-to-back with MAX_RD=4 → rd_pending=4 and host_ready=0. One ctl_rvalid with 32'h12345678 → host_rvalid with that data the next cycle, rd_pending=3, host_ready=1.
- Accept a read in the same cycle as a ctl_rvalid with rd_pending=2 → rd_pending stays 2.
- ctl_rvalid with rd_pending=0 → no host_rvalid, err=1 and sticky; rst clears err.
- 3 queued requests and 2 pending reads, then rst for 1 cycle → ctl_valid=0, rd_pending=0, all outputs at reset values the next cycle.
